game_master_fsm_multi_target: RTL and testbench
===============================================

// Module: game_master_fsm_multi_target
// PURPOSE
//  Game sequencer for the torpedo game, generalised to N_TARGETS independent targets,
//  a limited magazine of SHOTS torpedoes, a score counter and a selectable escape mode.
//  Sits between the sprite engines (per-target + one torpedo) and the end-of-game timer.
//  Drives sprite write/update strobes and reports win/loss, score and shots left.
// PARAMETERS
//  N_TARGETS         3  number of target sprites (>=1)
//  SHOTS             4  torpedoes per game (>=1)
//  ESCAPE_ENDS_GAME  1  1: any live target leaving screen ends game as loss; 0: that target is just retired
//  SCORE_W   $clog2(N_TARGETS+1)  score width (localparam); SHOT_W = $clog2(SHOTS+1)
// PORTS
//  clk                           in   1          clock
//  rst                           in   1          synchronous reset, active-high
//  launch_key                    in   1          fire request (level, sampled in AIM)
//  sprite_target_write_xy        out  N_TARGETS  load start position, per target
//  sprite_target_write_dxy       out  N_TARGETS  load velocity, per target
//  sprite_target_enable_update   out  N_TARGETS  allow motion, per target
//  sprite_torpedo_write_xy       out  1          load torpedo start position
//  sprite_torpedo_write_dxy      out  1          load torpedo launch velocity
//  sprite_torpedo_enable_update  out  1          allow torpedo motion
//  sprite_target_within_screen   in   N_TARGETS  per-target on-screen flag
//  sprite_torpedo_within_screen  in   1          torpedo on-screen flag
//  collision                     in   N_TARGETS  torpedo overlaps target i
//  end_of_game_timer_start       out  1          1-cycle pulse starting end timer
//  end_of_game_timer_running     in   1          end timer busy
//  game_won / game_lost          out  1 / 1      result, held through END
//  score                         out  SCORE_W    targets destroyed this game
//  shots_left                    out  SHOT_W     torpedoes remaining
// BEHAVIOUR
//  - All outputs registered: decision made from state+inputs in cycle t appears at t+1.
//  - Reset: state=START, every output 0, alive mask 0, END guard flag 0.
//  - rst has priority on any cycle, incl. mid-SHOOT/END; next cycle is START.
//  - alive[N_TARGETS-1:0] internal; only alive targets get enable_update; "escape" =
//    alive[i] & ~within_screen[i].
//  START (1 cycle): target_write_xy/dxy = all ones, torpedo_write_xy=1; alive=all ones;
//    score=0; shots_left=SHOTS; game_won=game_lost=0 -> AIM.
//  AIM: target_enable_update=alive. Priority order:
//    1 escape & ESCAPE_ENDS_GAME -> game_lost=1, timer_start, -> END
//    1' escape & !ESCAPE_ENDS_GAME -> clear alive[i]; if alive becomes 0 -> END, won iff score>0
//    2 launch_key & shots_left>0 -> shots_left-1, torpedo_write_dxy=1, -> SHOOT
//  SHOOT: target_enable_update=alive, torpedo_enable_update=1.
//    hits = collision & alive; score += popcount(hits) (simultaneous hits all count); alive &= ~hits.
//    Exit when hits!=0 or torpedo off screen: torpedo_write_xy=1, then
//      alive' == 0            -> game_won=1, timer_start, END
//      else shots_left == 0   -> game_lost=1, timer_start, END
//      else                   -> AIM
//    Escape handled as in AIM, evaluated after hits (a target hit and escaping same cycle counts as hit).
//  END: all enable_update 0; collisions ignored; results/score frozen. First END cycle
//    ignores timer_running (guard for registered timer_start); from 2nd cycle,
//    !end_of_game_timer_running -> START.
//  - launch_key in SHOOT/END/START ignored; no queued shots.
//  - Score saturates at N_TARGETS (cannot exceed by construction; assert).
// TESTING
//  1 reset then idle, timer_running=0: cycle1 START strobes all ones, AIM; shots_left=4, score=0.
//  2 N=3: launch, collision=3'b010 during SHOOT -> score=1, alive=101, torpedo_write_xy pulse, back to AIM, shots_left=3.
//  3 collision=3'b111 in one SHOOT cycle -> score=3, game_won=1, timer_start 1-cycle pulse, END.
//  4 four shots all exit screen without hit -> game_lost=1, shots_left=0, END; launch_key then ignored.
//  5 ESCAPE_ENDS_GAME=1: within_screen[2]=0 in AIM -> game_lost; =0: target 2 retired, game continues.
//  6 timer_running=1 for 5 cycles after END: END held, START 1 cycle after it drops; rst mid-SHOOT -> START next.

Source files
------------

// File: rtl/game_master_fsm_multi_target.sv
// Torpedo game sequencer: N targets, limited magazine, score, escape mode.
// Ports: clk/rst, launch_key, sprite strobes/flags, collision, end timer, results.
module game_master_fsm_multi_target #(
  parameter int N_TARGETS        = 3,
  parameter int SHOTS            = 4,
  parameter bit ESCAPE_ENDS_GAME = 1'b1,
  localparam int SCORE_W = $clog2(N_TARGETS + 1),
  localparam int SHOT_W  = $clog2(SHOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_key,
  output logic [N_TARGETS-1:0] sprite_target_write_xy,
  output logic [N_TARGETS-1:0] sprite_target_write_dxy,
  output logic [N_TARGETS-1:0] sprite_target_enable_update,
  output logic                 sprite_torpedo_write_xy,
  output logic                 sprite_torpedo_write_dxy,
  output logic                 sprite_torpedo_enable_update,
  input  logic [N_TARGETS-1:0] sprite_target_within_screen,
  input  logic                 sprite_torpedo_within_screen,
  input  logic [N_TARGETS-1:0] collision,
  output logic                 end_of_game_timer_start,
  input  logic                 end_of_game_timer_running,
  output logic                 game_won,
  output logic                 game_lost,
  output logic [SCORE_W-1:0]   score,
  output logic [SHOT_W-1:0]    shots_left
);

  typedef enum logic [1:0] {
    S_START,
    S_AIM,
    S_SHOOT,
    S_END
  } state_e;

  localparam logic [SHOT_W-1:0]  SHOTS_V   = SHOT_W'(SHOTS);
  localparam logic [SCORE_W:0]   SCORE_MAX = (SCORE_W + 1)'(N_TARGETS);
  localparam logic [N_TARGETS-1:0] ALL = '1;

  state_e               state_q, state_d;
  logic [N_TARGETS-1:0] alive_q, alive_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SHOT_W-1:0]    shots_q, shots_d;
  logic                 won_q, won_d;
  logic                 lost_q, lost_d;
  logic                 guard_q, guard_d;
  logic [N_TARGETS-1:0] t_wxy_q, t_wxy_d;
  logic [N_TARGETS-1:0] t_wdxy_q, t_wdxy_d;
  logic [N_TARGETS-1:0] t_en_q, t_en_d;
  logic                 p_wxy_q, p_wxy_d;
  logic                 p_wdxy_q, p_wdxy_d;
  logic                 p_en_q, p_en_d;
  logic                 ts_q, ts_d;

  logic [N_TARGETS-1:0] hits;
  logic [N_TARGETS-1:0] alive_h;
  logic [N_TARGETS-1:0] esc;
  logic [SCORE_W-1:0]   hit_cnt;
  logic                 leave;

  always_comb begin
    state_d  = state_q;
    alive_d  = alive_q;
    score_d  = score_q;
    shots_d  = shots_q;
    won_d    = won_q;
    lost_d   = lost_q;
    t_wxy_d  = '0;
    t_wdxy_d = '0;
    t_en_d   = '0;
    p_wxy_d  = 1'b0;
    p_wdxy_d = 1'b0;
    p_en_d   = 1'b0;
    ts_d     = 1'b0;
    hits     = '0;
    alive_h  = alive_q;
    esc      = '0;
    hit_cnt  = '0;
    leave    = 1'b0;
    unique case (state_q)
      S_START: begin
        t_wxy_d  = ALL;
        t_wdxy_d = ALL;
        p_wxy_d  = 1'b1;
        alive_d  = ALL;
        score_d  = '0;
        shots_d  = SHOTS_V;
        won_d    = 1'b0;
        lost_d   = 1'b0;
        state_d  = S_AIM;
      end
      S_AIM: begin
        esc = alive_q & ~sprite_target_within_screen;
        if (esc != '0 && ESCAPE_ENDS_GAME) begin
          lost_d  = 1'b1;
          ts_d    = 1'b1;
          state_d = S_END;
        end else if (esc != '0) begin
          alive_d = alive_q & ~esc;
          if (alive_d == '0) begin
            won_d   = (score_q != '0);
            lost_d  = (score_q == '0);
            ts_d    = 1'b1;
            state_d = S_END;
          end
        end else if (launch_key && shots_q != '0) begin
          shots_d  = shots_q - 1'b1;
          p_wdxy_d = 1'b1;
          state_d  = S_SHOOT;
        end
        t_en_d = alive_d;
      end
      S_SHOOT: begin
        hits = collision & alive_q;
        for (int i = 0; i < N_TARGETS; i++)
          hit_cnt = hit_cnt + SCORE_W'(hits[i]);
        score_d = score_q + hit_cnt;
        // Hits are resolved first so a target hit while
        // leaving the screen is scored, not escaped.
        alive_h = alive_q & ~hits;
        esc     = alive_h & ~sprite_target_within_screen;
        alive_d = ESCAPE_ENDS_GAME ? alive_h : (alive_h & ~esc);
        leave   = (hits != '0) || !sprite_torpedo_within_screen;
        p_wxy_d = leave;
        p_en_d  = 1'b1;
        if (esc != '0 && ESCAPE_ENDS_GAME) begin
          lost_d  = 1'b1;
          ts_d    = 1'b1;
          state_d = S_END;
        end else if (alive_d == '0) begin
          won_d   = (score_d != '0);
          lost_d  = (score_d == '0);
          ts_d    = 1'b1;
          state_d = S_END;
        end else if (leave) begin
          if (shots_q == '0) begin
            lost_d  = 1'b1;
            ts_d    = 1'b1;
            state_d = S_END;
          end else begin
            state_d = S_AIM;
          end
        end
        t_en_d = alive_d;
      end
      S_END: begin
        // timer_start is registered, so the timer cannot
        // report running until our second END cycle.
        if (!guard_q && !end_of_game_timer_running)
          state_d = S_START;
      end
      default: state_d = S_START;
    endcase
    guard_d = (state_d == S_END) && (state_q != S_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_START;
      alive_q  <= '0;
      score_q  <= '0;
      shots_q  <= '0;
      won_q    <= 1'b0;
      lost_q   <= 1'b0;
      guard_q  <= 1'b0;
      t_wxy_q  <= '0;
      t_wdxy_q <= '0;
      t_en_q   <= '0;
      p_wxy_q  <= 1'b0;
      p_wdxy_q <= 1'b0;
      p_en_q   <= 1'b0;
      ts_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      alive_q  <= alive_d;
      score_q  <= score_d;
      shots_q  <= shots_d;
      won_q    <= won_d;
      lost_q   <= lost_d;
      guard_q  <= guard_d;
      t_wxy_q  <= t_wxy_d;
      t_wdxy_q <= t_wdxy_d;
      t_en_q   <= t_en_d;
      p_wxy_q  <= p_wxy_d;
      p_wdxy_q <= p_wdxy_d;
      p_en_q   <= p_en_d;
      ts_q     <= ts_d;
    end
  end

  score_bound_a: assert property (
    @(posedge clk) disable iff (rst)
    {1'b0, score_q} <= SCORE_MAX);

  assign sprite_target_write_xy       = t_wxy_q;
  assign sprite_target_write_dxy      = t_wdxy_q;
  assign sprite_target_enable_update  = t_en_q;
  assign sprite_torpedo_write_xy      = p_wxy_q;
  assign sprite_torpedo_write_dxy     = p_wdxy_q;
  assign sprite_torpedo_enable_update = p_en_q;
  assign end_of_game_timer_start      = ts_q;
  assign game_won                     = won_q;
  assign game_lost                    = lost_q;
  assign score                        = score_q;
  assign shots_left                   = shots_q;

endmodule

// File: tb/tb_game_master_fsm_multi_target.sv
// Bench for game_master_fsm_multi_target: two instances, escape ends
// game (dut) and escape retires target (dut_r), same stimulus.
module tb_game_master_fsm_multi_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       launch_key;
  logic [2:0] tws;
  logic [2:0] col;
  logic       pws;
  logic       trun;

  logic [2:0] twxy1, twdxy1, ten1;
  logic       pwxy1, pwdxy1, pen1, ts1, won1, lost1;
  logic [1:0] sc1;
  logic [2:0] sh1;
  logic [2:0] twxy0, twdxy0, ten0;
  logic       pwxy0, pwdxy0, pen0, ts0, won0, lost0;
  logic [1:0] sc0;
  logic [2:0] sh0;

  logic [19:0] obs1, obs0;

  typedef struct {
    logic        r;
    logic        k;
    logic [2:0]  tw;
    logic [2:0]  cl;
    logic        pw;
    logic        tr;
    logic [19:0] e1;
    logic [19:0] e0;
  } row_t;

  row_t        rows[$];
  logic [39:0] sb[$];
  logic [39:0] exp_v;
  logic [19:0] S;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  game_master_fsm_multi_target #(
    .N_TARGETS(3), .SHOTS(4), .ESCAPE_ENDS_GAME(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .launch_key(launch_key),
    .sprite_target_write_xy(twxy1),
    .sprite_target_write_dxy(twdxy1),
    .sprite_target_enable_update(ten1),
    .sprite_torpedo_write_xy(pwxy1),
    .sprite_torpedo_write_dxy(pwdxy1),
    .sprite_torpedo_enable_update(pen1),
    .sprite_target_within_screen(tws),
    .sprite_torpedo_within_screen(pws),
    .collision(col),
    .end_of_game_timer_start(ts1),
    .end_of_game_timer_running(trun),
    .game_won(won1), .game_lost(lost1),
    .score(sc1), .shots_left(sh1)
  );

  game_master_fsm_multi_target #(
    .N_TARGETS(3), .SHOTS(4), .ESCAPE_ENDS_GAME(1'b0)
  ) dut_r (
    .clk(clk), .rst(rst), .launch_key(launch_key),
    .sprite_target_write_xy(twxy0),
    .sprite_target_write_dxy(twdxy0),
    .sprite_target_enable_update(ten0),
    .sprite_torpedo_write_xy(pwxy0),
    .sprite_torpedo_write_dxy(pwdxy0),
    .sprite_torpedo_enable_update(pen0),
    .sprite_target_within_screen(tws),
    .sprite_torpedo_within_screen(pws),
    .collision(col),
    .end_of_game_timer_start(ts0),
    .end_of_game_timer_running(trun),
    .game_won(won0), .game_lost(lost0),
    .score(sc0), .shots_left(sh0)
  );

  assign obs1 = {twxy1, twdxy1, ten1, pwxy1, pwdxy1, pen1,
                 ts1, won1, lost1, sc1, sh1};
  assign obs0 = {twxy0, twdxy0, ten0, pwxy0, pwdxy0, pen0,
                 ts0, won0, lost0, sc0, sh0};

  // Expected output vector, same field order as obs1/obs0.
  function automatic logic [19:0] mk(
    input int a, b, c, d, e, f, g, h, i, s, n);
    return {3'(a), 3'(b), 3'(c), 1'(d), 1'(e), 1'(f),
            1'(g), 1'(h), 1'(i), 2'(s), 3'(n)};
  endfunction

  task automatic add2(input int r, k, tw, cl, pw, tr,
                      input logic [19:0] e1, e0);
    row_t x;
    x.r = 1'(r); x.k = 1'(k);
    x.tw = 3'(tw); x.cl = 3'(cl);
    x.pw = 1'(pw); x.tr = 1'(tr);
    x.e1 = e1; x.e0 = e0;
    rows.push_back(x);
  endtask

  task automatic add(input int r, k, tw, cl, pw, tr,
                     input logic [19:0] e);
    add2(r, k, tw, cl, pw, tr, e, e);
  endtask

  task automatic test_reset();
    rows.delete();
    add(1, 0, 7, 0, 1, 0, 20'd0);
    add(1, 1, 7, 7, 1, 0, 20'd0);
    add(0, 0, 7, 0, 1, 0, S);
    add(0, 0, 7, 0, 1, 0, mk(0,0,7,0,0,0,0,0,0,0,4));
    add(0, 0, 7, 0, 1, 0, mk(0,0,7,0,0,0,0,0,0,0,4));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].r; launch_key = rows[i].k;
      tws = rows[i].tw; col = rows[i].cl;
      pws = rows[i].pw; trun = rows[i].tr;
      sb.push_back({rows[i].e1, rows[i].e0});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({obs1, obs0} !== exp_v) begin
        bad++;
        $display("FAIL reset row%0d got %b/%b want %b/%b",
                 i, obs1, obs0, exp_v[39:20], exp_v[19:0]);
      end
    end
  endtask

  task automatic test_single_hit();
    rows.delete();
    add(1, 0, 7, 0, 1, 0, 20'd0);
    add(0, 0, 7, 0, 1, 0, S);
    add(0, 1, 7, 0, 1, 0, mk(0,0,7,0,1,0,0,0,0,0,3));
    add(0, 1, 7, 0, 1, 0, mk(0,0,7,0,0,1,0,0,0,0,3));
    add(0, 0, 7, 2, 1, 0, mk(0,0,5,1,0,1,0,0,0,1,3));
    add(0, 0, 7, 2, 1, 0, mk(0,0,5,0,0,0,0,0,0,1,3));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].r; launch_key = rows[i].k;
      tws = rows[i].tw; col = rows[i].cl;
      pws = rows[i].pw; trun = rows[i].tr;
      sb.push_back({rows[i].e1, rows[i].e0});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({obs1, obs0} !== exp_v) begin
        bad++;
        $display("FAIL single_hit row%0d got %b/%b want %b/%b",
                 i, obs1, obs0, exp_v[39:20], exp_v[19:0]);
      end
    end
  endtask

  task automatic test_multi_hit();
    logic [19:0] e;
    e = mk(0,0,0,0,0,0,0,1,0,3,3);
    rows.delete();
    add(1, 0, 7, 0, 1, 0, 20'd0);
    add(0, 0, 7, 0, 1, 0, S);
    add(0, 1, 7, 0, 1, 0, mk(0,0,7,0,1,0,0,0,0,0,3));
    add(0, 0, 7, 7, 1, 0, mk(0,0,0,1,0,1,1,1,0,3,3));
    add(0, 0, 7, 7, 1, 0, e);
    add(0, 0, 7, 0, 1, 0, e);
    add(0, 0, 7, 0, 1, 0, S);
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].r; launch_key = rows[i].k;
      tws = rows[i].tw; col = rows[i].cl;
      pws = rows[i].pw; trun = rows[i].tr;
      sb.push_back({rows[i].e1, rows[i].e0});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({obs1, obs0} !== exp_v) begin
        bad++;
        $display("FAIL multi_hit row%0d got %b/%b want %b/%b",
                 i, obs1, obs0, exp_v[39:20], exp_v[19:0]);
      end
    end
  endtask

  task automatic test_all_miss();
    logic [19:0] l;
    l = mk(0,0,0,0,0,0,0,0,1,0,0);
    rows.delete();
    add(1, 0, 7, 0, 1, 0, 20'd0);
    add(0, 0, 7, 0, 1, 0, S);
    for (int k = 3; k >= 1; k--) begin
      add(0, 1, 7, 0, 1, 0, mk(0,0,7,0,1,0,0,0,0,0,k));
      add(0, 0, 7, 0, 0, 0, mk(0,0,7,1,0,1,0,0,0,0,k));
    end
    add(0, 1, 7, 0, 1, 0, mk(0,0,7,0,1,0,0,0,0,0,0));
    add(0, 0, 7, 0, 0, 0, mk(0,0,7,1,0,1,1,0,1,0,0));
    add(0, 1, 7, 0, 1, 1, l);
    add(0, 1, 7, 0, 1, 1, l);
    add(0, 1, 7, 0, 1, 0, l);
    add(0, 1, 7, 0, 1, 0, S);
    add(0, 0, 7, 0, 1, 0, mk(0,0,7,0,0,0,0,0,0,0,4));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].r; launch_key = rows[i].k;
      tws = rows[i].tw; col = rows[i].cl;
      pws = rows[i].pw; trun = rows[i].tr;
      sb.push_back({rows[i].e1, rows[i].e0});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({obs1, obs0} !== exp_v) begin
        bad++;
        $display("FAIL all_miss row%0d got %b/%b want %b/%b",
                 i, obs1, obs0, exp_v[39:20], exp_v[19:0]);
      end
    end
  endtask

  task automatic test_escape();
    logic [19:0] l;
    logic [19:0] a;
    l = mk(0,0,0,0,0,0,0,0,1,0,4);
    a = mk(0,0,3,0,0,0,0,0,0,0,4);
    rows.delete();
    add(1, 0, 7, 0, 1, 0, 20'd0);
    add(0, 0, 7, 0, 1, 0, S);
    add2(0, 0, 3, 0, 1, 0, mk(0,0,7,0,0,0,1,0,1,0,4), a);
    add2(0, 0, 3, 0, 1, 0, l, a);
    add2(0, 1, 3, 0, 1, 0, l, mk(0,0,3,0,1,0,0,0,0,0,3));
    add2(0, 0, 3, 3, 1, 0, S, mk(0,0,0,1,0,1,1,1,0,2,3));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].r; launch_key = rows[i].k;
      tws = rows[i].tw; col = rows[i].cl;
      pws = rows[i].pw; trun = rows[i].tr;
      sb.push_back({rows[i].e1, rows[i].e0});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({obs1, obs0} !== exp_v) begin
        bad++;
        $display("FAIL escape row%0d got %b/%b want %b/%b",
                 i, obs1, obs0, exp_v[39:20], exp_v[19:0]);
      end
    end
  endtask

  task automatic test_timer_rst();
    logic [19:0] e;
    e = mk(0,0,0,0,0,0,0,1,0,3,3);
    rows.delete();
    add(1, 0, 7, 0, 1, 0, 20'd0);
    add(0, 0, 7, 0, 1, 0, S);
    add(0, 1, 7, 0, 1, 0, mk(0,0,7,0,1,0,0,0,0,0,3));
    add(0, 0, 7, 7, 1, 1, mk(0,0,0,1,0,1,1,1,0,3,3));
    for (int k = 0; k < 5; k++)
      add(0, 0, 7, 0, 1, 1, e);
    add(0, 0, 7, 0, 1, 0, e);
    add(0, 0, 7, 0, 1, 0, S);
    add(0, 1, 7, 0, 1, 0, mk(0,0,7,0,1,0,0,0,0,0,3));
    add(0, 0, 7, 0, 1, 0, mk(0,0,7,0,0,1,0,0,0,0,3));
    add(1, 0, 7, 0, 1, 0, 20'd0);
    add(0, 0, 7, 0, 1, 0, S);
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].r; launch_key = rows[i].k;
      tws = rows[i].tw; col = rows[i].cl;
      pws = rows[i].pw; trun = rows[i].tr;
      sb.push_back({rows[i].e1, rows[i].e0});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({obs1, obs0} !== exp_v) begin
        bad++;
        $display("FAIL timer_rst row%0d got %b/%b want %b/%b",
                 i, obs1, obs0, exp_v[39:20], exp_v[19:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    launch_key = 1'b0;
    tws = 3'b111;
    col = 3'b000;
    pws = 1'b1;
    trun = 1'b0;
    S = mk(7,7,0,1,0,0,0,0,0,0,4);
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_all_miss();
    test_escape();
    test_timer_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
